// File: rtl/pcie_sym_monitor.sv
// ---------------------------------------------------------------------------
// pcie_sym_monitor
//
// Passive monitor for a descrambled, 8b/10b-decoded PCIe symbol stream.
// Frames the symbols into TLPs, DLLPs and ordered sets. Reports one event per
// beat that terminated a packet, keeps saturating event counters, and holds a
// sticky framing-error flag.
//
// Parameters
//   LANES  symbols per beat (1, 2, 4, 8); lane 0 is earliest in time
//   LEN_W  packet length counter width
//   CNT_W  event counter width
//
// Ports
//   CLK, RESET    single clock, synchronous active-high reset
//   sym_val       beat valid; beats with sym_val low do not advance the parser
//   sym_data      symbols, lane i in bits [8i+7:8i]
//   sym_k         per-lane K flag
//   cnt_clr       synchronous clear of counters and ferr (wins over events)
//   pkt_done      one-cycle pulse: the previous beat terminated a packet
//   pkt_type      0 TLP good, 1 TLP nullified, 2 DLLP, 3 aborted
//   pkt_len       data symbols between start and end symbol (exclusive)
//   tlp_cnt, null_cnt, dllp_cnt, os_cnt, ferr_cnt   saturating counters
//   ferr          sticky framing-error flag
//   state_o       current parser state (0 IDLE, 1 TLP, 2 DLLP)
// ---------------------------------------------------------------------------
module pcie_sym_monitor #(
    parameter int LANES = 8,
    parameter int LEN_W = 12,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             sym_val,
    input  logic [63:0]      sym_data,
    input  logic [7:0]       sym_k,
    input  logic             cnt_clr,
    output logic             pkt_done,
    output logic [1:0]       pkt_type,
    output logic [LEN_W-1:0] pkt_len,
    output logic [CNT_W-1:0] tlp_cnt,
    output logic [CNT_W-1:0] null_cnt,
    output logic [CNT_W-1:0] dllp_cnt,
    output logic [CNT_W-1:0] os_cnt,
    output logic [CNT_W-1:0] ferr_cnt,
    output logic             ferr,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TLP  = 2'd1,
        S_DLLP = 2'd2
    } state_t;

    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;
    localparam logic [7:0] K_COM = 8'hBC;

    localparam int EV_W = $clog2(LANES + 1);
    localparam logic [LEN_W-1:0] DLLP_LEN = LEN_W'(6);

    // Counter plus per-beat event count, clamped at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [EV_W-1:0]  b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W + 1 - EV_W){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    function automatic logic [LEN_W-1:0] inc_len_sat(input logic [LEN_W-1:0] l);
        return (l == {LEN_W{1'b1}}) ? l : l + LEN_W'(1);
    endfunction

    state_t           state_p1;
    logic [LEN_W-1:0] len_p1;

    state_t           st_c;
    state_t           nst;
    logic [LEN_W-1:0] ln_c;
    logic [LEN_W-1:0] nln;
    logic [7:0]       sym;
    logic             abort;
    logic             fin;
    logic             idle_err;
    logic [1:0]       ftype;
    logic [EV_W-1:0]  n_tlp, n_null, n_dllp, n_os, n_ferr;
    logic             any_done;
    logic [1:0]       last_type;
    logic [LEN_W-1:0] last_len;

    // Stage 0: unrolled per-lane parser chain, lane 0 first. Each lane sees
    // the state/length left behind by the lane before it.
    always_comb begin
        st_c      = state_p1;
        ln_c      = len_p1;
        nst       = state_p1;
        nln       = len_p1;
        sym       = 8'h00;
        abort     = 1'b0;
        fin       = 1'b0;
        idle_err  = 1'b0;
        ftype     = 2'd0;
        n_tlp     = '0;
        n_null    = '0;
        n_dllp    = '0;
        n_os      = '0;
        n_ferr    = '0;
        any_done  = 1'b0;
        last_type = 2'd0;
        last_len  = '0;
        for (int i = 0; i < LANES; i++) begin
            sym      = sym_data[8*i +: 8];
            nst      = st_c;
            nln      = ln_c;
            abort    = 1'b0;
            fin      = 1'b0;
            idle_err = 1'b0;
            ftype    = 2'd0;
            if (!sym_k[i]) begin
                if (st_c == S_TLP) begin
                    nln = inc_len_sat(ln_c);
                end else if (st_c == S_DLLP) begin
                    // A DLLP carries exactly six data symbols; a seventh aborts it.
                    if (ln_c < DLLP_LEN) begin
                        nln = ln_c + LEN_W'(1);
                    end else begin
                        abort = 1'b1;
                        nst   = S_IDLE;
                    end
                end
            end else begin
                case (sym)
                    K_STP: begin
                        abort = (st_c != S_IDLE);
                        nst   = S_TLP;
                        nln   = '0;
                    end
                    K_SDP: begin
                        abort = (st_c != S_IDLE);
                        nst   = S_DLLP;
                        nln   = '0;
                    end
                    K_COM: begin
                        abort = (st_c != S_IDLE);
                        n_os  = n_os + EV_W'(1);
                        nst   = S_IDLE;
                    end
                    K_END: begin
                        case (st_c)
                            S_TLP: begin
                                fin   = 1'b1;
                                ftype = 2'd0;
                                n_tlp = n_tlp + EV_W'(1);
                            end
                            S_DLLP: begin
                                if (ln_c == DLLP_LEN) begin
                                    fin    = 1'b1;
                                    ftype  = 2'd2;
                                    n_dllp = n_dllp + EV_W'(1);
                                end else begin
                                    abort = 1'b1;
                                end
                            end
                            default: idle_err = 1'b1;
                        endcase
                        nst = S_IDLE;
                    end
                    K_EDB: begin
                        case (st_c)
                            S_TLP: begin
                                fin    = 1'b1;
                                ftype  = 2'd1;
                                n_null = n_null + EV_W'(1);
                            end
                            S_DLLP:  abort    = 1'b1;
                            default: idle_err = 1'b1;
                        endcase
                        nst = S_IDLE;
                    end
                    default: ;
                endcase
            end
            if (abort) begin
                fin   = 1'b1;
                ftype = 2'd3;
            end
            if (abort || idle_err) begin
                n_ferr = n_ferr + EV_W'(1);
            end
            // Report uses the length before this symbol acted on it.
            if (fin) begin
                any_done  = 1'b1;
                last_type = ftype;
                last_len  = ln_c;
            end
            st_c = nst;
            ln_c = nln;
        end
    end

    // Stage 1: parser state register; idle beats hold state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_p1 <= S_IDLE;
            len_p1   <= '0;
        end else if (sym_val) begin
            state_p1 <= st_c;
            len_p1   <= ln_c;
        end
    end

    // Stage 1: packet report, counters and sticky error.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pkt_done <= 1'b0;
            pkt_type <= 2'd0;
            pkt_len  <= '0;
            tlp_cnt  <= '0;
            null_cnt <= '0;
            dllp_cnt <= '0;
            os_cnt   <= '0;
            ferr_cnt <= '0;
            ferr     <= 1'b0;
        end else begin
            pkt_done <= sym_val && any_done;
            if (sym_val && any_done) begin
                pkt_type <= last_type;
                pkt_len  <= last_len;
            end
            if (cnt_clr) begin
                tlp_cnt  <= '0;
                null_cnt <= '0;
                dllp_cnt <= '0;
                os_cnt   <= '0;
                ferr_cnt <= '0;
                ferr     <= 1'b0;
            end else if (sym_val) begin
                tlp_cnt  <= sat_add(tlp_cnt, n_tlp);
                null_cnt <= sat_add(null_cnt, n_null);
                dllp_cnt <= sat_add(dllp_cnt, n_dllp);
                os_cnt   <= sat_add(os_cnt, n_os);
                ferr_cnt <= sat_add(ferr_cnt, n_ferr);
                if (n_ferr != '0) begin
                    ferr <= 1'b1;
                end
            end
        end
    end

    assign state_o = state_p1;

endmodule

// File: tb/tb_pcie_sym_monitor.sv
module tb_pcie_sym_monitor;

    localparam int LANES = 8;
    localparam int LEN_W = 12;
    localparam int CNT_W = 32;

    localparam logic [8:0] STP = 9'h1FB;
    localparam logic [8:0] SDP = 9'h15C;
    localparam logic [8:0] ENDS = 9'h1FD;
    localparam logic [8:0] EDB = 9'h1FE;
    localparam logic [8:0] COM = 9'h1BC;
    localparam logic [8:0] SKP = 9'h11C;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             sym_val = 1'b0;
    logic [63:0]      sym_data = '0;
    logic [7:0]       sym_k = '0;
    logic             cnt_clr = 1'b0;
    logic             pkt_done;
    logic [1:0]       pkt_type;
    logic [LEN_W-1:0] pkt_len;
    logic [CNT_W-1:0] tlp_cnt, null_cnt, dllp_cnt, os_cnt, ferr_cnt;
    logic             ferr;
    logic [1:0]       state_o;

    // Narrow instance for length and counter saturation.
    logic       d2_done;
    logic [1:0] d2_type;
    logic [2:0] d2_len;
    logic [3:0] d2_tlp, d2_null, d2_dllp, d2_os, d2_ferr_cnt;
    logic       d2_ferr;
    logic [1:0] d2_state;

    pcie_sym_monitor #(.LANES(LANES), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .sym_val(sym_val), .sym_data(sym_data),
        .sym_k(sym_k), .cnt_clr(cnt_clr), .pkt_done(pkt_done),
        .pkt_type(pkt_type), .pkt_len(pkt_len), .tlp_cnt(tlp_cnt),
        .null_cnt(null_cnt), .dllp_cnt(dllp_cnt), .os_cnt(os_cnt),
        .ferr_cnt(ferr_cnt), .ferr(ferr), .state_o(state_o)
    );

    pcie_sym_monitor #(.LANES(LANES), .LEN_W(3), .CNT_W(4)) dut2 (
        .CLK(CLK), .RESET(RESET), .sym_val(sym_val), .sym_data(sym_data),
        .sym_k(sym_k), .cnt_clr(cnt_clr), .pkt_done(d2_done),
        .pkt_type(d2_type), .pkt_len(d2_len), .tlp_cnt(d2_tlp),
        .null_cnt(d2_null), .dllp_cnt(d2_dllp), .os_cnt(d2_os),
        .ferr_cnt(d2_ferr_cnt), .ferr(d2_ferr), .state_o(d2_state)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int exp_t[$];
    int exp_l[$];
    logic [8:0] txq[$];
    logic clr_b = 1'b0;
    int mon_t, mon_l;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic expect_pkt(input int t, input int l);
        exp_t.push_back(t);
        exp_l.push_back(l);
    endtask

    task automatic add_data(input int n);
        for (int i = 0; i < n; i++) txq.push_back({1'b0, 8'(8'h10 + i)});
    endtask

    // Sends the queued symbols as back-to-back beats, padding with SKP.
    task automatic flush();
        logic [8:0] s;
        while (txq.size() > 0) begin
            for (int i = 0; i < LANES; i++) begin
                s = (txq.size() > 0) ? txq.pop_front() : SKP;
                sym_data[8*i +: 8] = s[7:0];
                sym_k[i] = s[8];
            end
            sym_val = 1'b1;
            cnt_clr = clr_b;
            @(posedge CLK);
            #1;
        end
        sym_val = 1'b0;
        cnt_clr = 1'b0;
    endtask

    // Scoreboard monitor: every pkt_done pops one expected packet.
    always @(negedge CLK) begin
        if (!RESET && pkt_done) begin
            checks++;
            if (exp_t.size() == 0) begin
                errors++;
                $display("FAIL pkt_done unexpected: type=%0d len=%0d", pkt_type, pkt_len);
            end else begin
                mon_t = exp_t.pop_front();
                mon_l = exp_l.pop_front();
                if (int'(pkt_type) != mon_t || int'(pkt_len) != mon_l) begin
                    errors++;
                    $display("FAIL pkt report: got type=%0d len=%0d expected type=%0d len=%0d",
                             pkt_type, pkt_len, mon_t, mon_l);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("reset pkt_done", pkt_done, 0);
        chk("reset pkt_type", pkt_type, 0);
        chk("reset pkt_len", pkt_len, 0);
        chk("reset tlp_cnt", tlp_cnt, 0);
        chk("reset os_cnt", os_cnt, 0);
        chk("reset ferr_cnt", ferr_cnt, 0);
        chk("reset ferr", ferr, 0);
        chk("reset state", state_o, 0);

        // TLP spanning three beats
        txq.push_back(STP); add_data(18); txq.push_back(ENDS);
        expect_pkt(0, 18);
        flush();
        chk("t1 tlp_cnt", tlp_cnt, 1);
        chk("t1 ferr", ferr, 0);

        // DLLP in one beat
        txq.push_back(SDP); add_data(6); txq.push_back(ENDS);
        expect_pkt(2, 6);
        flush();
        chk("t2 dllp_cnt", dllp_cnt, 1);

        // Nullified TLP
        txq.push_back(STP); add_data(10); txq.push_back(EDB);
        expect_pkt(1, 10);
        flush();
        chk("t3 null_cnt", null_cnt, 1);
        chk("t3 tlp_cnt", tlp_cnt, 1);

        // DLLP overrun aborts on the seventh data symbol
        txq.push_back(SDP); add_data(7);
        expect_pkt(3, 6);
        flush();
        chk("t4 ferr_cnt", ferr_cnt, 1);
        chk("t4 ferr", ferr, 1);
        chk("t4 dllp_cnt", dllp_cnt, 1);
        chk("t4 state", state_o, 0);
        txq.push_back(ENDS);
        flush();
        chk("t4 idle END ferr_cnt", ferr_cnt, 2);

        // TLP aborted by SDP, then the DLLP completes in the next beat
        txq.push_back(STP); add_data(2); txq.push_back(SDP); add_data(6); txq.push_back(ENDS);
        expect_pkt(3, 2);
        expect_pkt(2, 6);
        flush();
        chk("t4b ferr_cnt", ferr_cnt, 3);
        chk("t4b dllp_cnt", dllp_cnt, 2);

        // Ordered sets, then the same beat with a clear
        for (int r = 0; r < 2; r++) begin
            txq.push_back(COM); txq.push_back(SKP); txq.push_back(SKP); txq.push_back(SKP);
        end
        flush();
        chk("t5 os_cnt", os_cnt, 2);
        for (int r = 0; r < 2; r++) begin
            txq.push_back(COM); txq.push_back(SKP); txq.push_back(SKP); txq.push_back(SKP);
        end
        clr_b = 1'b1;
        flush();
        clr_b = 1'b0;
        chk("t5 clr os_cnt", os_cnt, 0);
        chk("t5 clr ferr", ferr, 0);
        chk("t5 clr ferr_cnt", ferr_cnt, 0);
        chk("t5 clr tlp_cnt", tlp_cnt, 0);

        // Reset mid-TLP discards the packet
        txq.push_back(STP); add_data(3);
        flush();
        chk("t6 state mid tlp", state_o, 1);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk("t6 state after reset", state_o, 0);
        chk("t6 pkt_done after reset", pkt_done, 0);
        txq.push_back(STP); add_data(4); txq.push_back(ENDS);
        expect_pkt(0, 4);
        flush();
        chk("t6 tlp_cnt", tlp_cnt, 1);

        // Several events in one beat
        txq.push_back(STP); txq.push_back(ENDS); txq.push_back(STP); add_data(1);
        txq.push_back(EDB); txq.push_back(COM); txq.push_back(STP); txq.push_back(STP);
        expect_pkt(3, 0);
        flush();
        chk("t7 tlp_cnt", tlp_cnt, 2);
        chk("t7 null_cnt", null_cnt, 1);
        chk("t7 os_cnt", os_cnt, 1);
        chk("t7 ferr_cnt", ferr_cnt, 1);
        chk("t7 state", state_o, 1);
        add_data(2); txq.push_back(COM);
        expect_pkt(3, 2);
        flush();
        chk("t7 com abort os_cnt", os_cnt, 2);
        chk("t7 com abort ferr_cnt", ferr_cnt, 2);
        chk("t7 com abort state", state_o, 0);

        // Length saturation on the narrow instance
        txq.push_back(STP); add_data(9); txq.push_back(ENDS);
        expect_pkt(0, 9);
        flush();
        chk("t8 tlp_cnt", tlp_cnt, 3);
        chk("t8 narrow len sat", d2_len, 7);
        chk("t8 narrow type", d2_type, 0);

        // Counter saturation on the narrow instance
        txq.push_back(SKP);
        clr_b = 1'b1;
        flush();
        clr_b = 1'b0;
        chk("t9 narrow os cleared", d2_os, 0);
        for (int i = 0; i < 8; i++) txq.push_back(COM);
        flush();
        chk("t9 narrow os 8", d2_os, 8);
        for (int i = 0; i < 8; i++) txq.push_back(COM);
        flush();
        chk("t9 narrow os sat", d2_os, 15);
        chk("t9 wide os", os_cnt, 16);
        txq.push_back(COM);
        flush();
        chk("t9 narrow os hold", d2_os, 15);
        chk("t9 wide os +1", os_cnt, 17);

        repeat (2) @(posedge CLK);
        #1;
        chk("scoreboard drained", exp_t.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
